uart_alu_if: RTL
================

Name: uart_alu_if

Overview:
- Upstream/downstream glue between a byte-serial link (UART RX/TX) and the top-level ALU.
- Collects three received bytes (operand A, operand B, opcode) and drives them to the ALU's data_a/data_b/op inputs in place of the switch/button loading path.
- Captures the ALU result and hands it to the UART transmitter as one byte.
- Lets the ALU be exercised from a host instead of board switches.

Parameters:
NB_DATA, 8, width of operands, result and UART bytes
NB_OP, 6, ALU opcode width; taken from the low NB_OP bits of the third byte
TIMEOUT_CYCLES, 50000, inter-byte timeout in clk cycles (used only with the optional feature)
NB_TIMEOUT, 16, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all logic on the rising edge
i_rst  in  1  reset, asynchronous, active-high
i_rx_data  in  NB_DATA  received byte, valid when i_rx_valid=1
i_rx_valid  in  1  one-cycle pulse per received byte
i_alu_result  in  NB_DATA  combinational ALU result (signed)
i_tx_done  in  1  one-cycle pulse when the transmitter finishes a byte
o_alu_data_a  out  NB_DATA  registered operand A
o_alu_data_b  out  NB_DATA  registered operand B
o_alu_op  out  NB_OP  registered opcode
o_tx_data  out  NB_DATA  registered result byte for the transmitter
o_tx_start  out  1  registered one-cycle start pulse to the transmitter
o_busy  out  1  high in any state other than IDLE
o_timeout  out  1  one-cycle pulse on inter-byte timeout (optional feature)

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0. Reset is asynchronous and aborts any transaction in any state. No partial result is sent.
- States and transitions:
  - IDLE: on i_rx_valid, latch o_alu_data_a <= i_rx_data, go to GET_B.
  - GET_B: on i_rx_valid, latch o_alu_data_b, go to GET_OP.
  - GET_OP: on i_rx_valid, latch o_alu_op <= i_rx_data[NB_OP-1:0] (upper bits ignored), go to EXEC.
  - EXEC: one settle cycle for the combinational ALU. At the end of the cycle, o_tx_data <= i_alu_result. Go to SEND.
  - SEND: assert o_tx_start=1 for exactly the next cycle, then go to WAIT_TX.
  - WAIT_TX: hold until i_tx_done=1, then go to IDLE.
- Latency: i_rx_valid of the opcode byte in cycle N:
  - o_alu_op valid in N+1 (EXEC)
  - o_tx_data valid from N+2
  - o_tx_start high in cycle N+3
- Operands and op hold their values after a transaction until overwritten by the next one. The ALU output remains valid for display.
- i_rx_valid in EXEC, SEND or WAIT_TX: byte is dropped, no state change.
- i_tx_done outside WAIT_TX: ignored.
- i_rx_valid and i_tx_done in the same WAIT_TX cycle: go to IDLE; the byte is dropped (it is not taken as operand A).
- o_tx_start is never asserted outside the single SEND->WAIT_TX cycle. Exactly one start pulse per completed 3-byte frame.
- o_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_ALU_IF_TIMEOUT_EN.
- Defined:
  - A counter runs in GET_B and GET_OP. It clears on every accepted byte and on entry to IDLE.
  - Reaching TIMEOUT_CYCLES-1 without i_rx_valid returns the FSM to IDLE and pulses o_timeout for one cycle.
  - Already-latched operand registers keep their values. No transmission occurs.
  - i_rx_valid in the same cycle as expiry wins: the byte is accepted and no timeout fires.
- Undefined: no counter is instantiated, o_timeout is tied to 0, and the FSM waits indefinitely for the next byte.

Test Plan:
- Reset, then bytes 15, 10, 0x20 (ADD); bench ALU model returns 25 -> o_alu_data_a=15, o_alu_data_b=10, o_alu_op=6'b100000; o_tx_data=25; single o_tx_start pulse 3 cycles after the opcode byte; i_tx_done -> o_busy=0.
- Bytes 25, 5, 0x22 (SUB) back-to-back with a 1-cycle gap -> o_alu_op=6'b100010, o_tx_data=20. A fourth byte sent during WAIT_TX is dropped, and the next frame starts cleanly.
- Opcode byte 0xE4 -> o_alu_op=6'b100100 (upper bits dropped); operands 12, 10 -> o_tx_data=8.
- Assert i_rst after 2 bytes (state GET_OP) -> all outputs 0 immediately, asynchronously. After release, a fresh frame 8, 4, 0x25 -> o_tx_data=12.
- With UART_ALU_IF_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 1 byte, then idle for 100 cycles -> o_timeout pulses once, state IDLE, no o_tx_start. The next byte is taken as operand A.
- Without the macro, the same stimulus -> no timeout; o_busy stays 1 until the remaining two bytes arrive.

Source files
------------

// File: rtl/uart_alu_if.sv
// uart_alu_if: gathers three UART bytes (operand A, operand B, opcode) for the ALU and
// returns its result as one byte to the transmitter. Define UART_ALU_IF_TIMEOUT_EN for the inter-byte timeout.
module uart_alu_if #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NB_TIMEOUT     = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout
);

  // Handshake: i_rx_valid and i_tx_done are one-cycle strobes with no back-pressure. A byte is
  // taken only in IDLE/GET_B/GET_OP, i_tx_done only counts in WAIT_TX, o_tx_start is a one-cycle strobe.
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GET_B   = 3'd1;
  localparam logic [2:0] GET_OP  = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       timeout_hit;

`ifdef UART_ALU_IF_TIMEOUT_EN
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] timeout_cnt;
  logic                  collecting;

  assign collecting  = (state == GET_B) || (state == GET_OP);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = collecting && !i_rx_valid && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      timeout_cnt <= '0;
      o_timeout   <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
      if (!collecting || i_rx_valid || timeout_hit) timeout_cnt <= '0;
      else                                          timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_rx_valid) next_state = GET_B;
      GET_B:   if (i_rx_valid) next_state = GET_OP;
               else if (timeout_hit) next_state = IDLE;
      GET_OP:  if (i_rx_valid) next_state = EXEC;
               else if (timeout_hit) next_state = IDLE;
      EXEC:    next_state = SEND;
      SEND:    next_state = WAIT_TX;
      WAIT_TX: if (i_tx_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_tx_start   <= 1'b0;
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_op     <= '0;
      o_tx_data    <= '0;
    end else begin
      state      <= next_state;
      o_busy     <= (next_state != IDLE);
      o_tx_start <= (state == SEND);
      if (state == IDLE   && i_rx_valid) o_alu_data_a <= i_rx_data;
      if (state == GET_B  && i_rx_valid) o_alu_data_b <= i_rx_data;
      if (state == GET_OP && i_rx_valid) o_alu_op     <= i_rx_data[NB_OP-1:0];
      // EXEC gives the combinational ALU one full cycle to settle on the new operands.
      if (state == EXEC) o_tx_data <= i_alu_result;
    end
  end

endmodule
